// File: rtl/print_pkg.sv
// ---------------------------------------------------------------------------
// print_pkg
// Shared types and helpers for the sprite print engine.
//   state_t          : print FSM state encoding
//   DEF_BG_CODE      : default "no sprite, background" compare code
//   bg_addr_default  : default background-colour address (top of memory)
//   sat_inc16        : 16-bit saturating increment
// ---------------------------------------------------------------------------
package print_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        BG     = 2'd2,
        SPRITE = 2'd3
    } state_t;

    localparam int unsigned DEF_BG_CODE = 1;
    localparam int unsigned DEF_ADDR_W  = 14;

    // Background colour lives in the last word of sprite memory.
    function automatic int unsigned bg_addr_default(input int unsigned aw);
        return (32'd1 << aw) - 32'd1;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/print_frame_stats.sv
// ---------------------------------------------------------------------------
// print_frame_stats
// Per-frame status: sticky sprite-abort flag and saturating sprite counter,
// both cleared at the first blank line.
//   clk, reset        : clock, async active-high reset
//   i_sprite_start    : a sprite line is starting this cycle
//   i_sprite_abort    : a streaming sprite is being aborted this cycle
//   i_frame_start     : first blank line (frame boundary)
//   o_overrun         : sticky, a sprite was aborted this frame
//   o_sprite_count    : sprites started this frame, saturating
// ---------------------------------------------------------------------------
module print_frame_stats
    import print_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        i_sprite_start,
    input  logic        i_sprite_abort,
    input  logic        i_frame_start,
    output logic        o_overrun,
    output logic [15:0] o_sprite_count
);

    logic        r_overrun;
    logic [15:0] r_sprite_count;

    // A sprite starting on the boundary cycle belongs to the new frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_overrun      <= 1'b0;
            r_sprite_count <= 16'd0;
        end else if (i_frame_start) begin
            r_overrun      <= i_sprite_abort;
            r_sprite_count <= i_sprite_start ? 16'd1 : 16'd0;
        end else begin
            if (i_sprite_abort) begin
                r_overrun <= 1'b1;
            end
            if (i_sprite_start) begin
                r_sprite_count <= sat_inc16(r_sprite_count);
            end
        end
    end

    assign o_overrun      = r_overrun;
    assign o_sprite_count = r_sprite_count;

endmodule

// File: rtl/sprite_print_engine.sv
// ---------------------------------------------------------------------------
// sprite_print_engine
// Samples the VGA coordinate in the active area, issues a compare to the
// sprite register bank, waits CMP_LAT cycles, then either fetches the
// background colour or streams one sprite line under out_ready back-pressure.
//   clk, reset        : clock, async active-high reset
//   i_active_area     : monitor in visible region
//   i_pixel_x/y       : current column / row
//   i_data_reg        : compare result, valid CMP_LAT cycles after check_valid
//   i_out_ready       : downstream accepts the current beat
//   o_check_value     : {pixel_x, pixel_y} for compare
//   o_check_valid     : one-cycle compare strobe
//   o_memory_address  : background fetch address
//   o_mem_rd          : background fetch strobe
//   o_sprite_datas    : latched sprite descriptor
//   o_sprite_on       : sprite line streaming
//   o_sprite_col      : column index within sprite line
//   o_printing        : pixel_y < V_ACTIVE
//   o_overrun         : sticky, sprite aborted this frame
//   o_sprite_count    : sprites started this frame, saturating
// ---------------------------------------------------------------------------
module sprite_print_engine
    import print_pkg::*;
#(
    parameter int unsigned X_W        = 10,
    parameter int unsigned Y_W        = 10,
    parameter int unsigned ADDR_W     = DEF_ADDR_W,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned SPRITE_LEN = 20,
    parameter int unsigned CMP_LAT    = 1,
    parameter int unsigned BG_HOLD    = 2,
    parameter int unsigned BG_CODE    = DEF_BG_CODE,
    parameter int unsigned BG_ADDR    = bg_addr_default(ADDR_W),
    parameter int unsigned V_ACTIVE   = 480
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_active_area,
    input  logic [X_W-1:0]       i_pixel_x,
    input  logic [Y_W-1:0]       i_pixel_y,
    input  logic [DATA_W-1:0]    i_data_reg,
    input  logic                 i_out_ready,
    output logic [X_W+Y_W-1:0]   o_check_value,
    output logic                 o_check_valid,
    output logic [ADDR_W-1:0]    o_memory_address,
    output logic                 o_mem_rd,
    output logic [DATA_W-1:0]    o_sprite_datas,
    output logic                 o_sprite_on,
    output logic [7:0]           o_sprite_col,
    output logic                 o_printing,
    output logic                 o_overrun,
    output logic [15:0]          o_sprite_count
);

    localparam int unsigned WAIT_W = 3;
    localparam int unsigned HOLD_W = 4;

    state_t                r_state;
    logic [WAIT_W-1:0]     r_wait;
    logic [HOLD_W-1:0]     r_hold;
    logic [X_W+Y_W-1:0]    r_check_value;
    logic                  r_check_valid;
    logic [ADDR_W-1:0]     r_memory_address;
    logic                  r_mem_rd;
    logic [DATA_W-1:0]     r_sprite_datas;
    logic                  r_sprite_on;
    logic [7:0]            r_sprite_col;
    logic                  r_printing;

    logic                  w_data_ready;
    logic                  w_is_bg;
    logic                  w_sprite_start;
    logic                  w_sprite_abort;
    logic                  w_frame_start;

    // The wait count runs CMP_LAT..0, so data_reg is sampled CMP_LAT cycles
    // after the cycle in which check_valid was visible.
    assign w_data_ready   = (r_state == WAIT) && i_active_area && (r_wait == '0);
    assign w_is_bg        = (i_data_reg == DATA_W'(BG_CODE));
    assign w_sprite_start = w_data_ready && !w_is_bg;
    assign w_sprite_abort = (r_state == SPRITE) && !i_active_area;
    assign w_frame_start  = (i_pixel_y == Y_W'(V_ACTIVE));

    // Print FSM with registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state          <= IDLE;
            r_wait           <= '0;
            r_hold           <= '0;
            r_check_value    <= '0;
            r_check_valid    <= 1'b0;
            r_memory_address <= '0;
            r_mem_rd         <= 1'b0;
            r_sprite_datas   <= '0;
            r_sprite_on      <= 1'b0;
            r_sprite_col     <= 8'd0;
            r_printing       <= 1'b0;
        end else begin
            r_check_valid <= 1'b0;
            r_mem_rd      <= 1'b0;
            r_printing    <= (i_pixel_y < Y_W'(V_ACTIVE));

            case (r_state)
                IDLE: begin
                    if (i_active_area) begin
                        r_check_value <= {i_pixel_x, i_pixel_y};
                        r_check_valid <= 1'b1;
                        r_wait        <= WAIT_W'(CMP_LAT);
                        r_state       <= WAIT;
                    end
                end

                WAIT: begin
                    if (!i_active_area) begin
                        r_state <= IDLE;
                    end else if (r_wait == '0) begin
                        if (w_is_bg) begin
                            r_memory_address <= ADDR_W'(BG_ADDR);
                            r_mem_rd         <= 1'b1;
                            r_hold           <= '0;
                            r_state          <= BG;
                        end else begin
                            r_sprite_datas <= i_data_reg;
                            r_sprite_col   <= 8'd0;
                            r_sprite_on    <= 1'b1;
                            r_state        <= SPRITE;
                        end
                    end else begin
                        r_wait <= r_wait - WAIT_W'(1);
                    end
                end

                BG: begin
                    if (!i_active_area) begin
                        r_state <= IDLE;
                    end else if (i_out_ready) begin
                        if (r_hold == HOLD_W'(BG_HOLD - 1)) begin
                            r_state <= IDLE;
                        end else begin
                            r_hold <= r_hold + HOLD_W'(1);
                        end
                    end
                end

                SPRITE: begin
                    if (!i_active_area) begin
                        r_sprite_on <= 1'b0;
                        r_state     <= IDLE;
                    end else if (i_out_ready) begin
                        if (r_sprite_col == 8'(SPRITE_LEN - 1)) begin
                            r_sprite_on <= 1'b0;
                            r_state     <= IDLE;
                        end else begin
                            r_sprite_col <= r_sprite_col + 8'd1;
                        end
                    end
                end

                default: r_state <= IDLE;
            endcase
        end
    end

    print_frame_stats u_stats (
        .clk            (clk),
        .reset          (reset),
        .i_sprite_start (w_sprite_start),
        .i_sprite_abort (w_sprite_abort),
        .i_frame_start  (w_frame_start),
        .o_overrun      (o_overrun),
        .o_sprite_count (o_sprite_count)
    );

    assign o_check_value    = r_check_value;
    assign o_check_valid    = r_check_valid;
    assign o_memory_address = r_memory_address;
    assign o_mem_rd         = r_mem_rd;
    assign o_sprite_datas   = r_sprite_datas;
    assign o_sprite_on      = r_sprite_on;
    assign o_sprite_col     = r_sprite_col;
    assign o_printing       = r_printing;

endmodule
